alu_share_arbiter: RTL and testbench

- Shares one RV32I ALU instance among N_REQ requesters, for example an integer issue pipe and an address-generation pipe.
- Arbitration is round-robin. Each requester uses a valid/ready request port; responses return on a shared result bus with per-requester valid.
- Two-stage pipeline: issue register, then ALU, then response register. Throughput is one operation per cycle; latency is 2 cycles.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 38 +++
 rtl/dl_rr_arbiter.sv | 28 ++
 rtl/alu_share_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// RV32I ALU operation encodings shared by the ALU and its users.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b0001;
  localparam alu_op_t ALU_SLL  = 4'b0010;
  localparam alu_op_t ALU_SLT  = 4'b0100;
  localparam alu_op_t ALU_SLTU = 4'b0110;
  localparam alu_op_t ALU_XOR  = 4'b1000;
  localparam alu_op_t ALU_SRL  = 4'b1010;
  localparam alu_op_t ALU_SRA  = 4'b1011;
  localparam alu_op_t ALU_OR   = 4'b1100;
  localparam alu_op_t ALU_AND  = 4'b1110;

  // True for every encoding the ALU implements.
  function automatic logic alu_op_legal(input alu_op_t op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU; illegal encodings return zero with err set.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS = 32
) (
  input  alu_op_t           op,
  input  logic [N_BITS-1:0] in0,
  input  logic [N_BITS-1:0] in1,
  output logic [N_BITS-1:0] out,
  output logic              err
);

  localparam int unsigned SH_BITS = $clog2(N_BITS);

  logic [SH_BITS-1:0] shamt;
  assign shamt = in1[SH_BITS-1:0];

  // Result select; results wrap modulo 2^N_BITS.
  always_comb begin
    out = '0;
    err = !alu_op_legal(op);
    case (op)
      ALU_ADD:  out = in0 + in1;
      ALU_SUB:  out = in0 - in1;
      ALU_SLL:  out = in0 << shamt;
      ALU_SLT:  out = {{(N_BITS-1){1'b0}}, ($signed(in0) < $signed(in1))};
      ALU_SLTU: out = {{(N_BITS-1){1'b0}}, (in0 < in1)};
      ALU_XOR:  out = in0 ^ in1;
      ALU_SRL:  out = in0 >> shamt;
      ALU_SRA:  out = N_BITS'($signed(in0) >>> shamt);
      ALU_OR:   out = in0 | in1;
      ALU_AND:  out = in0 & in1;
      default:  out = '0;
    endcase
  end

endmodule

// File: rtl/dl_rr_arbiter.sv
// Rotate-priority pick: first asserted request at or above ptr, wrapping at N.
module dl_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = PW'((int'(ptr) + k) % int'(N));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin issue, two-stage pipe.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS   = 32,
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned TAG_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_val,
  output logic [N_REQ-1:0]          req_rdy,
  input  logic [N_REQ*4-1:0]        req_op,
  input  logic [N_REQ*N_BITS-1:0]   req_a,
  input  logic [N_REQ*N_BITS-1:0]   req_b,
  input  logic [N_REQ*TAG_BITS-1:0] req_tag,
  output logic [N_REQ-1:0]          resp_val,
  input  logic [N_REQ-1:0]          resp_rdy,
  output logic [N_BITS-1:0]         resp_data,
  output logic [TAG_BITS-1:0]       resp_tag,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int unsigned SRC_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                s1_val;
  alu_op_t             s1_op;
  logic [N_BITS-1:0]   s1_a;
  logic [N_BITS-1:0]   s1_b;
  logic [TAG_BITS-1:0] s1_tag;
  logic [SRC_BITS-1:0] s1_src;

  logic                s2_val;
  logic [N_BITS-1:0]   s2_data;
  logic                s2_err;
  logic [TAG_BITS-1:0] s2_tag;
  logic [SRC_BITS-1:0] s2_src;

  logic [SRC_BITS-1:0] rr_ptr;
  logic [SRC_BITS-1:0] ptr_next;
  logic [N_REQ-1:0]    grant;
  logic                resp_fire;
  logic                s1_en;
  logic                s2_en;
  logic                req_fire;

  alu_op_t             sel_op;
  logic [N_BITS-1:0]   sel_a;
  logic [N_BITS-1:0]   sel_b;
  logic [TAG_BITS-1:0] sel_tag;
  logic [SRC_BITS-1:0] sel_src;

  logic [N_BITS-1:0]   alu_out;
  logic                alu_err;

  dl_rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_val),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  alu #(.N_BITS(N_BITS)) u_alu (
    .op  (s1_op),
    .in0 (s1_a),
    .in1 (s1_b),
    .out (alu_out),
    .err (alu_err)
  );

  assign resp_fire = s2_val & resp_rdy[s2_src];
  assign s2_en     = !s2_val | resp_fire;
  assign s1_en     = !s1_val | s2_en;
  assign req_rdy   = grant & {N_REQ{s1_en}};
  assign req_fire  = |(req_val & req_rdy);
  assign ptr_next  = (sel_src == SRC_BITS'(N_REQ - 1)) ? '0 : sel_src + SRC_BITS'(1);

  assign resp_data = s2_data;
  assign resp_tag  = s2_tag;
  assign resp_err  = s2_err;
  assign busy      = s1_val | s2_val;

  // Mux out the payload of the (at most one) granted requester.
  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    sel_src = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) begin
        sel_op  = req_op[4*i +: 4];
        sel_a   = req_a[N_BITS*i +: N_BITS];
        sel_b   = req_b[N_BITS*i +: N_BITS];
        sel_tag = req_tag[TAG_BITS*i +: TAG_BITS];
        sel_src = SRC_BITS'(i);
      end
    end
  end

  // Per-requester response valid decoded from the owning source.
  always_comb begin
    resp_val = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      resp_val[i] = s2_val && (s2_src == SRC_BITS'(i));
    end
  end

  // Issue stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_val <= 1'b0;
      s1_op  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
      s1_src <= '0;
      rr_ptr <= '0;
    end else begin
      if (s1_en) begin
        s1_val <= req_fire;
        s1_op  <= sel_op;
        s1_a   <= sel_a;
        s1_b   <= sel_b;
        s1_tag <= sel_tag;
        s1_src <= sel_src;
      end
      if (req_fire) begin
        rr_ptr <= ptr_next;
      end
    end
  end

  // Response stage; holds while the owner withholds resp_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_val  <= 1'b0;
      s2_data <= '0;
      s2_err  <= 1'b0;
      s2_tag  <= '0;
      s2_src  <= '0;
    end else if (s2_en) begin
      s2_val  <= s1_val;
      s2_data <= alu_out;
      s2_err  <= alu_err;
      s2_tag  <= s1_tag;
      s2_src  <= s1_src;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a queue-based reference model.
module tb_alu_share_arbiter;

  localparam int NR = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_tag;
  logic [1:0]  resp_val;
  logic [1:0]  resp_rdy;
  logic [31:0] resp_data;
  logic [3:0]  resp_tag;
  logic        resp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.N_BITS(32), .N_REQ(2), .TAG_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .resp_tag  (resp_tag),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {err, data}.
  function automatic logic [32:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          sh;
    sh = int'(b[4:0]);
    e  = 1'b0;
    r  = 32'd0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << sh;
      4'h4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h6: r = (a < b) ? 32'd1 : 32'd0;
      4'h8: r = a ^ b;
      4'hA: r = a >> sh;
      4'hB: r = 32'($signed(a) >>> sh);
      4'hC: r = a | b;
      4'hE: r = a & b;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  typedef struct {
    int          src;
    int          cyc;
    logic [31:0] data;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t mq[$];
  int   mptr = 0;
  int   cyc  = 0;

  // Model: ops queue in acceptance order; the head is visible two cycles after
  // its accept cycle; at most two ops in flight unless the head retires.
  always @(negedge clk) begin
    logic       vis;
    logic       rfire;
    logic [1:0] exp_rv;
    logic [1:0] exp_rdy;
    logic [32:0] m;
    int         g;
    exp_t       e;
    cyc++;
    if (rst) begin
      mq.delete();
      mptr = 0;
    end else begin
      vis    = (mq.size() > 0) && (mq[0].cyc <= cyc - 2);
      exp_rv = vis ? (2'b01 << mq[0].src) : 2'b00;
      chk("resp_val", 64'(resp_val), 64'(exp_rv));
      if (vis) begin
        chk("resp_data", 64'(resp_data), 64'(mq[0].data));
        chk("resp_tag", 64'(resp_tag), 64'(mq[0].tag));
        chk("resp_err", 64'(resp_err), 64'(mq[0].err));
      end
      chk("busy", 64'(busy), 64'(mq.size() > 0));
      rfire = vis && resp_rdy[mq[0].src];
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (mptr + k) % NR;
        if (g < 0 && req_val[idx]) g = idx;
      end
      exp_rdy = 2'b00;
      if (g >= 0 && (mq.size() < 2 || rfire)) exp_rdy[g] = 1'b1;
      chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      if (rfire) void'(mq.pop_front());
      if (exp_rdy != 2'b00) begin
        m      = model_alu(4'(req_op >> (4 * g)), 32'(req_a >> (32 * g)), 32'(req_b >> (32 * g)));
        e.src  = g;
        e.cyc  = cyc;
        e.data = m[31:0];
        e.err  = m[32];
        e.tag  = 4'(req_tag >> (4 * g));
        mq.push_back(e);
        mptr = (g + 1) % NR;
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    req_val[i]          = v;
    req_op[4*i +: 4]    = op;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
    req_tag[4*i +: 4]   = tag;
  endtask

  // One isolated op on requester i with literal latency/result expectations.
  task automatic run_one(input string name, input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] exp_data, input logic exp_err);
    logic [1:0] onehot;
    onehot = 2'b01 << i;
    repeat (3) @(posedge clk);
    #1;
    set_req(i, 1'b1, op, a, b, tag);
    @(negedge clk);
    chk({name, "_accept"}, 64'(req_rdy), 64'(onehot));
    @(posedge clk);
    #1;
    req_val = 2'b00;
    @(negedge clk);
    chk({name, "_c1_val"}, 64'(resp_val), 64'd0);
    @(negedge clk);
    chk({name, "_c2_val"}, 64'(resp_val), 64'(onehot));
    chk({name, "_data"}, 64'(resp_data), 64'(exp_data));
    chk({name, "_tag"}, 64'(resp_tag), 64'(tag));
    chk({name, "_err"}, 64'(resp_err), 64'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_tags [3];
    int         cur;
    int         seen;
    logic       took;
    rst      = 1'b1;
    req_val  = '0;
    req_op   = '0;
    req_a    = '0;
    req_b    = '0;
    req_tag  = '0;
    resp_rdy = 2'b11;

    // Pin the reference model with hand-computed values.
    chk("pin_add", model_alu(4'h0, 32'd5, 32'd7), {1'b0, 32'd12});
    chk("pin_sub", model_alu(4'h1, 32'd3, 32'd5), {1'b0, 32'hFFFF_FFFE});
    chk("pin_sltu", model_alu(4'h6, 32'd1, 32'hFFFF_FFFF), {1'b0, 32'd1});
    chk("pin_slt", model_alu(4'h4, 32'd1, 32'hFFFF_FFFF), {1'b0, 32'd0});
    chk("pin_sra", model_alu(4'hB, 32'h8000_0000, 32'h21), {1'b0, 32'hC000_0000});
    chk("pin_srl", model_alu(4'hA, 32'h8000_0000, 32'h21), {1'b0, 32'h4000_0000});
    chk("pin_ill", model_alu(4'h3, 32'd9, 32'd9), {1'b1, 32'd0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_val", 64'(resp_val), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(resp_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_one("add", 0, 4'h0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);

    // Round robin: req0 fired last, so req1 wins first and they alternate.
    repeat (3) @(posedge clk);
    #1;
    set_req(0, 1'b1, 4'h1, 32'd3, 32'd5, 4'd0);
    set_req(1, 1'b1, 4'h6, 32'd1, 32'hFFFF_FFFF, 4'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_rdy), (k % 2 == 0) ? 64'h2 : 64'h1);
      if (k >= 2) begin
        chk("rr_resp_val", 64'(resp_val), (k % 2 == 0) ? 64'h2 : 64'h1);
        chk("rr_resp_data", 64'(resp_data), (k % 2 == 0) ? 64'h1 : 64'hFFFF_FFFE);
      end
      @(posedge clk);
      #1;
    end
    req_val = 2'b00;

    run_one("illegal", 0, 4'h3, 32'd9, 32'd9, 4'd5, 32'd0, 1'b1);
    run_one("sra", 1, 4'hB, 32'h8000_0000, 32'h21, 4'd6, 32'hC000_0000, 1'b0);
    run_one("srl", 0, 4'hA, 32'h8000_0000, 32'h21, 4'd7, 32'h4000_0000, 1'b0);

    // Backpressure on requester 0: tags 1,2,3 must stay ordered and intact.
    repeat (3) @(posedge clk);
    #1;
    exp_tags[0] = 4'd1;
    exp_tags[1] = 4'd2;
    exp_tags[2] = 4'd3;
    resp_rdy = 2'b10;
    cur  = 1;
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 6) resp_rdy = 2'b11;
      set_req(0, cur <= 3, 4'h0, 32'(cur), 32'd100, 4'(cur));
      @(negedge clk);
      if (c >= 2 && c < 6) begin
        chk("bp_rdy", 64'(req_rdy), 64'd0);
        chk("bp_val", 64'(resp_val), 64'd1);
        chk("bp_tag_hold", 64'(resp_tag), 64'd1);
        chk("bp_data_hold", 64'(resp_data), 64'd101);
      end
      if (resp_val[0] && resp_rdy[0]) begin
        if (seen < 3) chk("bp_order", 64'(resp_tag), 64'(exp_tags[seen]));
        seen++;
      end
      took = req_rdy[0] & req_val[0];
      @(posedge clk);
      #1;
      if (took) cur++;
    end
    req_val = 2'b00;
    chk("bp_count", 64'(seen), 64'd3);

    // Random traffic with random response backpressure.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        logic [31:0] a;
        logic [31:0] b;
        case ($urandom_range(0, 3))
          0: a = 32'h8000_0000;
          1: a = 32'hFFFF_FFFF;
          2: a = 32'($urandom_range(0, 15));
          default: a = $urandom;
        endcase
        b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, b,
                4'($urandom_range(0, 15)));
      end
      resp_rdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      @(posedge clk);
      #1;
    end

    // Mid-stream reset with both stages occupied.
    resp_rdy = 2'b00;
    set_req(0, 1'b1, 4'h0, 32'd1, 32'd2, 4'd1);
    set_req(1, 1'b1, 4'h8, 32'd3, 32'd4, 4'd2);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_rdy", 64'(req_rdy), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_val", 64'(resp_val), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_data", 64'(resp_data), 64'd0);
    chk("async_rst_tag", 64'(resp_tag), 64'd0);
    chk("async_rst_err", 64'(resp_err), 64'd0);
    resp_rdy = 2'b11;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", 64'(req_rdy), 64'd1);
    @(posedge clk);
    #1;
    req_val = 2'b00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
